// File: rtl/proc_scheduler.sv
// rtl/proc_scheduler.sv - round-robin scheduler for the cached process slots
// Picks the running slot, handles slice expiry/exit/block/wake and allocates slots for spawns.
module proc_scheduler #(
  parameter int NPROC = 8,
  parameter int IDXW  = 3,
  parameter int ADDRW = 10,
  parameter int SLICE = 16
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             inst_done,
  input  logic             exit_req,
  input  logic             block_req,
  input  logic             wake_req,
  input  logic [IDXW-1:0]  wake_idx,
  input  logic             spawn_req,
  input  logic [ADDRW-1:0] spawn_pc,
  output logic             spawn_ack,
  output logic             spawn_fail,
  output logic [IDXW-1:0]  spawn_idx,
  output logic             init_we,
  output logic [IDXW-1:0]  init_idx,
  output logic [ADDRW-1:0] init_pc,
  output logic [IDXW-1:0]  cur_idx,
  output logic             cur_valid,
  output logic             switch,
  output logic             idle,
  output logic [NPROC-1:0] active_mask,
  output logic [NPROC-1:0] blocked_mask
);

  localparam int SCW = (SLICE > 1) ? $clog2(SLICE) : 1;
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_SWITCH = 2'd1;
  localparam logic [1:0] ST_IDLE   = 2'd2;
  localparam logic [NPROC-1:0] ONE = {{(NPROC-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [SCW-1:0]   slice_cnt;
  logic             running, done, do_exit, do_block, trig, stay;
  logic             spawn_take, spawn_ok, free_found, sel_found;
  logic [IDXW-1:0]  free_idx, sel_idx;
  logic [NPROC-1:0] cur_bit, wake_bit, free_bit;
  logic [NPROC-1:0] active_nx, blocked_nx, runnable_nx;
  int               j;

  // Lowest free slot, judged on the registered mask so a same-cycle exit is not reused.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NPROC - 1; i >= 0; i--) begin
      if (!active_mask[IDXW'(i)]) begin
        free_found = 1'b1;
        free_idx   = IDXW'(i);
      end
    end
  end

  assign running    = (state == ST_RUN);
  assign done       = running & inst_done;
  assign do_exit    = done & exit_req;
  assign do_block   = done & block_req & ~exit_req;
  assign trig       = done & (exit_req | block_req | (slice_cnt == SCW'(SLICE - 1)));
  assign spawn_take = spawn_req & ~spawn_ack;
  assign spawn_ok   = spawn_take & free_found;

  assign cur_bit  = ONE << cur_idx;
  assign wake_bit = ONE << wake_idx;
  assign free_bit = ONE << free_idx;

  // Wake is applied after block so a same-cycle wake on the blocking process is never lost.
  assign active_nx   = (active_mask & ~(do_exit ? cur_bit : '0)) | (spawn_ok ? free_bit : '0);
  assign blocked_nx  = (blocked_mask | (do_block ? cur_bit : '0))
                     & ~(wake_req ? wake_bit : '0) & ~(spawn_ok ? free_bit : '0);
  assign runnable_nx = active_nx & ~blocked_nx;

  // Round-robin scan from cur_idx+1; cur_idx itself is the last candidate.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = cur_idx;
    j         = 0;
    for (int k = NPROC; k >= 1; k--) begin
      j = (int'(cur_idx) + k) % NPROC;
      if (runnable_nx[IDXW'(j)]) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(j);
      end
    end
  end

  assign stay = ~exit_req & ~block_req & (sel_idx == cur_idx);

  always_ff @(posedge clka) begin
    if (rst) begin
      state        <= ST_RUN;
      slice_cnt    <= '0;
      active_mask  <= ONE;
      blocked_mask <= '0;
      cur_idx      <= '0;
      cur_valid    <= 1'b1;
      switch       <= 1'b0;
      idle         <= 1'b0;
      spawn_ack    <= 1'b0;
      spawn_fail   <= 1'b0;
      spawn_idx    <= '0;
      init_we      <= 1'b0;
      init_idx     <= '0;
      init_pc      <= '0;
    end else begin
      active_mask  <= active_nx;
      blocked_mask <= blocked_nx;
      spawn_ack    <= spawn_take;
      spawn_fail   <= spawn_take & ~free_found;
      spawn_idx    <= spawn_ok ? free_idx : '0;
      init_we      <= spawn_ok;
      init_idx     <= spawn_ok ? free_idx : '0;
      init_pc      <= spawn_ok ? spawn_pc : '0;
      switch       <= 1'b0;
      case (state)
        ST_RUN: begin
          if (trig) begin
            slice_cnt <= '0;
            if (!sel_found) begin
              state     <= ST_IDLE;
              cur_valid <= 1'b0;
              idle      <= 1'b1;
            end else if (!stay) begin
              state     <= ST_SWITCH;
              cur_valid <= 1'b0;
            end
          end else if (done) begin
            slice_cnt <= slice_cnt + 1'b1;
          end
        end
        ST_SWITCH: begin
          if (!sel_found) begin
            state <= ST_IDLE;
            idle  <= 1'b1;
          end else begin
            state     <= ST_RUN;
            cur_idx   <= sel_idx;
            cur_valid <= 1'b1;
            switch    <= 1'b1;
            slice_cnt <= '0;
          end
        end
        ST_IDLE: begin
          if (sel_found) begin
            state <= ST_SWITCH;
            idle  <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cur_valid <= 1'b0;
          idle      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_scheduler.sv
// tb/tb_proc_scheduler.sv - bench for proc_scheduler: directed scenarios plus random run vs reference model
module tb_proc_scheduler;
  localparam int NPROC = 8;
  localparam int IDXW  = 3;
  localparam int ADDRW = 10;
  localparam int SLICE = 4;

  logic             clka = 1'b0;
  logic             rst = 1'b1;
  logic             inst_done = 1'b0, exit_req = 1'b0, block_req = 1'b0;
  logic             wake_req = 1'b0, spawn_req = 1'b0;
  logic [IDXW-1:0]  wake_idx = '0;
  logic [ADDRW-1:0] spawn_pc = '0;
  logic             spawn_ack, spawn_fail, init_we, cur_valid, sw, idle;
  logic [IDXW-1:0]  spawn_idx, init_idx, cur_idx;
  logic [ADDRW-1:0] init_pc;
  logic [NPROC-1:0] active_mask, blocked_mask;

  int errors = 0;
  int checks = 0;

  proc_scheduler #(.NPROC(NPROC), .IDXW(IDXW), .ADDRW(ADDRW), .SLICE(SLICE)) dut (
    .clka(clka), .rst(rst), .inst_done(inst_done), .exit_req(exit_req), .block_req(block_req),
    .wake_req(wake_req), .wake_idx(wake_idx), .spawn_req(spawn_req), .spawn_pc(spawn_pc),
    .spawn_ack(spawn_ack), .spawn_fail(spawn_fail), .spawn_idx(spawn_idx), .init_we(init_we),
    .init_idx(init_idx), .init_pc(init_pc), .cur_idx(cur_idx), .cur_valid(cur_valid),
    .switch(sw), .idle(idle), .active_mask(active_mask), .blocked_mask(blocked_mask)
  );

  always #5 clka = ~clka;

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic run_insts(input int n);
    inst_done = 1'b1;
    repeat (n) tick();
    inst_done = 1'b0;
  endtask

  // Reference model: slot tables and a scheduling mode, advanced once per clock.
  bit               m_act[NPROC];
  bit               m_blk[NPROC];
  int               m_cur, m_slice, m_sidx;
  bit               m_valid, m_switch, m_idle, m_in_switch, m_ack, m_fail, m_we;
  logic [ADDRW-1:0] m_pc;

  function automatic int pick_next();
    for (int k = 1; k <= NPROC; k++) begin
      int c = (m_cur + k) % NPROC;
      if (m_act[c] && !m_blk[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NPROC-1:0] pack(input bit arr[NPROC]);
    logic [NPROC-1:0] v;
    for (int k = 0; k < NPROC; k++) v[k] = arr[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NPROC; k++) begin
      m_act[k] = (k == 0);
      m_blk[k] = 1'b0;
    end
    m_cur = 0; m_slice = 0; m_sidx = 0; m_pc = '0;
    m_valid = 1; m_switch = 0; m_idle = 0; m_in_switch = 0; m_ack = 0; m_fail = 0; m_we = 0;
  endtask

  task automatic model_step();
    int  free_slot = -1;
    int  nxt;
    bit  running, done, trig;
    for (int k = NPROC - 1; k >= 0; k--) if (!m_act[k]) free_slot = k;
    running = !m_in_switch && !m_idle;
    done    = running && inst_done;
    trig    = done && (exit_req || block_req || m_slice == SLICE - 1);
    if (done && exit_req) m_act[m_cur] = 0;
    else if (done && block_req) m_blk[m_cur] = 1;
    if (wake_req) m_blk[wake_idx] = 0;
    m_fail = 0;
    m_we   = 0;
    if (spawn_req && !m_ack) begin
      m_ack = 1;
      if (free_slot < 0) m_fail = 1;
      else begin
        m_act[free_slot] = 1; m_blk[free_slot] = 0;
        m_we = 1; m_sidx = free_slot; m_pc = spawn_pc;
      end
    end else begin
      m_ack = 0;
    end
    nxt = pick_next();
    m_switch = 0;
    if (running) begin
      if (trig) begin
        m_slice = 0;
        if (nxt < 0) begin m_idle = 1; m_valid = 0; end
        else if (!(nxt == m_cur && !exit_req && !block_req)) begin m_in_switch = 1; m_valid = 0; end
      end else if (done) begin
        m_slice++;
      end
    end else if (m_in_switch) begin
      m_in_switch = 0;
      if (nxt < 0) m_idle = 1;
      else begin m_cur = nxt; m_valid = 1; m_switch = 1; m_slice = 0; end
    end else if (nxt >= 0) begin
      m_idle = 0; m_in_switch = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (active_mask !== 8'h01 || blocked_mask !== 8'h00) begin errors++; $display("FAIL reset_masks: got act=%h blk=%h expected act=01 blk=00", active_mask, blocked_mask); end
    checks++; if (cur_idx !== 3'd0 || cur_valid !== 1'b1 || sw !== 1'b0 || idle !== 1'b0) begin errors++; $display("FAIL reset_cur: got idx=%0d v=%b sw=%b idle=%b expected 0 1 0 0", cur_idx, cur_valid, sw, idle); end
    checks++; if (spawn_ack !== 1'b0 || spawn_fail !== 1'b0 || init_we !== 1'b0) begin errors++; $display("FAIL reset_spawn: got ack=%b fail=%b we=%b expected 0 0 0", spawn_ack, spawn_fail, init_we); end
    rst = 1'b0;
  endtask

  task automatic test_spawn_slice();
    spawn_req = 1'b1; spawn_pc = 10'h040;
    tick();
    spawn_req = 1'b0;
    checks++; if (spawn_ack !== 1'b1 || spawn_fail !== 1'b0 || spawn_idx !== 3'd1) begin errors++; $display("FAIL spawn_ack: got ack=%b fail=%b idx=%0d expected 1 0 1", spawn_ack, spawn_fail, spawn_idx); end
    checks++; if (init_we !== 1'b1 || init_idx !== 3'd1 || init_pc !== 10'h040) begin errors++; $display("FAIL spawn_init: got we=%b idx=%0d pc=%h expected 1 1 040", init_we, init_idx, init_pc); end
    checks++; if (active_mask !== 8'h03) begin errors++; $display("FAIL spawn_active: got %h expected 03", active_mask); end
    inst_done = 1'b1;
    repeat (3) tick();
    checks++; if (cur_valid !== 1'b1 || cur_idx !== 3'd0) begin errors++; $display("FAIL slice_early: got v=%b idx=%0d expected 1 0", cur_valid, cur_idx); end
    tick();
    inst_done = 1'b0;
    checks++; if (cur_valid !== 1'b0 || sw !== 1'b0) begin errors++; $display("FAIL slice_gap: got v=%b sw=%b expected 0 0", cur_valid, sw); end
    tick();
    checks++; if (cur_idx !== 3'd1 || sw !== 1'b1 || cur_valid !== 1'b1) begin errors++; $display("FAIL slice_switch: got idx=%0d sw=%b v=%b expected 1 1 1", cur_idx, sw, cur_valid); end
    tick();
    checks++; if (sw !== 1'b0) begin errors++; $display("FAIL switch_pulse: got %b expected 0", sw); end
  endtask

  task automatic test_wrap();
    spawn_req = 1'b1; spawn_pc = 10'h080;
    tick();
    spawn_req = 1'b0;
    checks++; if (spawn_idx !== 3'd2 || active_mask !== 8'h07) begin errors++; $display("FAIL wrap_spawn: got idx=%0d act=%h expected 2 07", spawn_idx, active_mask); end
    run_insts(SLICE); tick();
    checks++; if (cur_idx !== 3'd2 || sw !== 1'b1) begin errors++; $display("FAIL wrap_to2: got idx=%0d sw=%b expected 2 1", cur_idx, sw); end
    run_insts(SLICE); tick();
    checks++; if (cur_idx !== 3'd0 || sw !== 1'b1) begin errors++; $display("FAIL wrap_to0: got idx=%0d sw=%b expected 0 1", cur_idx, sw); end
    run_insts(SLICE); tick();
    exit_req = 1'b1; run_insts(1); exit_req = 1'b0; tick();
    checks++; if (cur_idx !== 3'd2 || active_mask !== 8'h05) begin errors++; $display("FAIL exit1: got idx=%0d act=%h expected 2 05", cur_idx, active_mask); end
    exit_req = 1'b1; run_insts(1); exit_req = 1'b0; tick();
    checks++; if (cur_idx !== 3'd0 || active_mask !== 8'h01) begin errors++; $display("FAIL exit2: got idx=%0d act=%h expected 0 01", cur_idx, active_mask); end
    for (int i = 0; i < 6; i++) begin
      inst_done = (i < SLICE);
      tick();
      checks++; if (cur_valid !== 1'b1 || sw !== 1'b0 || cur_idx !== 3'd0) begin errors++; $display("FAIL sole_stay cyc %0d: got v=%b sw=%b idx=%0d expected 1 0 0", i, cur_valid, sw, cur_idx); end
    end
    inst_done = 1'b0;
  endtask

  task automatic test_block_wake();
    spawn_req = 1'b1; spawn_pc = 10'h0c0;
    tick();
    spawn_req = 1'b0;
    checks++; if (spawn_idx !== 3'd1) begin errors++; $display("FAIL bw_spawn: got %0d expected 1", spawn_idx); end
    run_insts(SLICE); tick();
    checks++; if (cur_idx !== 3'd1) begin errors++; $display("FAIL bw_to1: got %0d expected 1", cur_idx); end
    block_req = 1'b1; run_insts(1); block_req = 1'b0;
    checks++; if (cur_valid !== 1'b0) begin errors++; $display("FAIL bw_gap: got v=%b expected 0", cur_valid); end
    tick();
    checks++; if (cur_idx !== 3'd0 || sw !== 1'b1 || blocked_mask !== 8'h02) begin errors++; $display("FAIL bw_block: got idx=%0d sw=%b blk=%h expected 0 1 02", cur_idx, sw, blocked_mask); end
    wake_req = 1'b1; wake_idx = 3'd1; tick(); wake_req = 1'b0;
    checks++; if (blocked_mask !== 8'h00) begin errors++; $display("FAIL bw_wake: got %h expected 00", blocked_mask); end
    run_insts(SLICE); tick();
    checks++; if (cur_idx !== 3'd1 || sw !== 1'b1) begin errors++; $display("FAIL bw_back: got idx=%0d sw=%b expected 1 1", cur_idx, sw); end
  endtask

  task automatic test_exit_idle();
    int n;
    exit_req = 1'b1; run_insts(1); exit_req = 1'b0; tick();
    checks++; if (cur_idx !== 3'd0 || active_mask !== 8'h01) begin errors++; $display("FAIL ei_exit1: got idx=%0d act=%h expected 0 01", cur_idx, active_mask); end
    exit_req = 1'b1; run_insts(1); exit_req = 1'b0; tick();
    checks++; if (active_mask !== 8'h00 || idle !== 1'b1 || cur_valid !== 1'b0) begin errors++; $display("FAIL ei_idle: got act=%h idle=%b v=%b expected 00 1 0", active_mask, idle, cur_valid); end
    spawn_req = 1'b1; spawn_pc = 10'h100;
    tick();
    spawn_req = 1'b0;
    checks++; if (spawn_ack !== 1'b1 || spawn_idx !== 3'd0 || init_we !== 1'b1 || init_pc !== 10'h100 || active_mask !== 8'h01) begin errors++; $display("FAIL ei_spawn: got ack=%b idx=%0d we=%b pc=%h act=%h expected 1 0 1 100 01", spawn_ack, spawn_idx, init_we, init_pc, active_mask); end
    n = 0;
    while (sw !== 1'b1 && n < 4) begin tick(); n++; end
    checks++; if (sw !== 1'b1 || cur_idx !== 3'd0 || idle !== 1'b0 || cur_valid !== 1'b1) begin errors++; $display("FAIL ei_restart: got sw=%b idx=%0d idle=%b v=%b expected 1 0 0 1", sw, cur_idx, idle, cur_valid); end
  endtask

  task automatic test_full();
    for (int s = 1; s < NPROC; s++) begin
      spawn_req = 1'b1; spawn_pc = ADDRW'(s * 16);
      tick();
      spawn_req = 1'b0;
      checks++; if (spawn_idx !== IDXW'(s) || init_we !== 1'b1) begin errors++; $display("FAIL full_fill %0d: got idx=%0d we=%b expected %0d 1", s, spawn_idx, init_we, s); end
      tick();
    end
    checks++; if (active_mask !== 8'hff) begin errors++; $display("FAIL full_mask: got %h expected ff", active_mask); end
    spawn_req = 1'b1; tick(); spawn_req = 1'b0;
    checks++; if (spawn_ack !== 1'b1 || spawn_fail !== 1'b1 || init_we !== 1'b0) begin errors++; $display("FAIL full_reject: got ack=%b fail=%b we=%b expected 1 1 0", spawn_ack, spawn_fail, init_we); end
    repeat (3) begin run_insts(SLICE); tick(); end
    checks++; if (cur_idx !== 3'd3) begin errors++; $display("FAIL full_to3: got %0d expected 3", cur_idx); end
    block_req = 1'b1; wake_req = 1'b1; wake_idx = 3'd3;
    run_insts(1);
    block_req = 1'b0; wake_req = 1'b0;
    checks++; if (blocked_mask !== 8'h00 || cur_valid !== 1'b0) begin errors++; $display("FAIL full_bw: got blk=%h v=%b expected 00 0", blocked_mask, cur_valid); end
    tick();
    checks++; if (cur_idx !== 3'd4 || sw !== 1'b1) begin errors++; $display("FAIL full_yield: got idx=%0d sw=%b expected 4 1", cur_idx, sw); end
  endtask

  task automatic test_reset_mid();
    run_insts(SLICE);
    checks++; if (cur_valid !== 1'b0) begin errors++; $display("FAIL rm_gap: got v=%b expected 0", cur_valid); end
    rst = 1'b1; spawn_req = 1'b1; spawn_pc = 10'h3ff;
    tick();
    checks++; if (cur_idx !== 3'd0 || cur_valid !== 1'b1 || active_mask !== 8'h01 || blocked_mask !== 8'h00) begin errors++; $display("FAIL rm_state: got idx=%0d v=%b act=%h blk=%h expected 0 1 01 00", cur_idx, cur_valid, active_mask, blocked_mask); end
    checks++; if (spawn_ack !== 1'b0 || sw !== 1'b0 || init_we !== 1'b0) begin errors++; $display("FAIL rm_outs: got ack=%b sw=%b we=%b expected 0 0 0", spawn_ack, sw, init_we); end
    rst = 1'b0; spawn_req = 1'b0;
    tick();
    checks++; if (sw !== 1'b0 || spawn_ack !== 1'b0 || cur_idx !== 3'd0) begin errors++; $display("FAIL rm_after: got sw=%b ack=%b idx=%0d expected 0 0 0", sw, spawn_ack, cur_idx); end
  endtask

  task automatic test_random();
    rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      inst_done = ($urandom % 2 == 0);
      exit_req  = ($urandom % 16 == 0);
      block_req = ($urandom % 8 == 0);
      wake_req  = ($urandom % 4 == 0);
      wake_idx  = IDXW'($urandom % NPROC);
      if (!spawn_req) begin
        spawn_req = ($urandom % 5 == 0);
        spawn_pc  = ADDRW'($urandom);
      end
      model_step();
      tick();
      if (spawn_ack) spawn_req = 1'b0;
      checks++; if (cur_idx !== IDXW'(m_cur) || cur_valid !== m_valid || sw !== m_switch || idle !== m_idle) begin errors++; $display("FAIL rand_sched cyc %0d: got idx=%0d v=%b sw=%b idle=%b expected %0d %b %b %b", cyc, cur_idx, cur_valid, sw, idle, m_cur, m_valid, m_switch, m_idle); end
      checks++; if (active_mask !== pack(m_act) || blocked_mask !== pack(m_blk)) begin errors++; $display("FAIL rand_masks cyc %0d: got act=%h blk=%h expected %h %h", cyc, active_mask, blocked_mask, pack(m_act), pack(m_blk)); end
      checks++; if (spawn_ack !== m_ack || spawn_fail !== m_fail || init_we !== m_we) begin errors++; $display("FAIL rand_spawn cyc %0d: got ack=%b fail=%b we=%b expected %b %b %b", cyc, spawn_ack, spawn_fail, init_we, m_ack, m_fail, m_we); end
      if (m_we) begin
        checks++; if (spawn_idx !== IDXW'(m_sidx) || init_idx !== IDXW'(m_sidx) || init_pc !== m_pc) begin errors++; $display("FAIL rand_alloc cyc %0d: got sidx=%0d iidx=%0d pc=%h expected %0d %0d %h", cyc, spawn_idx, init_idx, init_pc, m_sidx, m_sidx, m_pc); end
      end
    end
    inst_done = 0; exit_req = 0; block_req = 0; wake_req = 0; spawn_req = 0;
  endtask

  initial begin
    test_reset();
    test_spawn_slice();
    test_wrap();
    test_block_wake();
    test_exit_idle();
    test_full();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/proc_scheduler.md
Name: proc_scheduler

Overview:
- Round-robin scheduler for the CPU's cached process slots. Decides which process_index the fetch/decode stages run.
- Switches at instruction boundaries on time-slice expiry, exit or block, and allocates free slots for spawned processes (OPCODE_PROC).
- Sits beside stage1. Stage1 reports instruction completion and process events; the scheduler returns the current index and the program-counter init writes into the address_pc table.

Parameters:
NPROC, 8, number of process slots
IDXW, 3, process index width (log2 NPROC)
ADDRW, 10, program address width
SLICE, 16, instructions per time slice (>=1)

Ports:
clka  in  1  single clock, all logic on posedge
rst  in  1  synchronous reset, active-high
inst_done  in  1  one-cycle pulse: current process finished an instruction
exit_req  in  1  current process terminates; valid only with inst_done
block_req  in  1  current process waits for wake; valid only with inst_done
wake_req  in  1  clear blocked flag of wake_idx
wake_idx  in  IDXW  process to wake
spawn_req  in  1  request new process; held until spawn_ack
spawn_pc  in  ADDRW  start address of new process
spawn_ack  out  1  one-cycle response to spawn_req
spawn_fail  out  1  with spawn_ack: no free slot
spawn_idx  out  IDXW  with spawn_ack: allocated slot
init_we  out  1  pulse: write init_pc into address_pc[init_idx]
init_idx  out  IDXW  slot to initialise
init_pc  out  ADDRW  initial pc
cur_idx  out  IDXW  process stage1 executes
cur_valid  out  1  cur_idx valid; stage1 stalls while 0
switch  out  1  one-cycle pulse: cur_idx changed; stage1 restarts at STAGE_READ_PC1_REQUEST
idle  out  1  no runnable process
active_mask  out  NPROC  allocated slots
blocked_mask  out  NPROC  blocked slots

Behaviour:
- Reset values: active_mask=1, blocked_mask=0, cur_idx=0, cur_valid=1, state RUN, slice_cnt=0. spawn_ack, spawn_fail, spawn_idx, init_we, init_idx, init_pc, switch and idle all 0.
- Reset mid-operation aborts any pending spawn (no ack) and any switch in progress.
- Runnable = active & ~blocked.
- State RUN:
  - inst_done increments slice_cnt.
  - Trigger = inst_done & (exit_req | block_req | slice_cnt==SLICE-1).
  - exit_req clears active[cur]. block_req sets blocked[cur]. exit_req takes priority if both are set.
  - exit_req/block_req without inst_done are ignored. inst_done outside RUN is ignored.
- Next selection, done on the trigger cycle using updated masks:
  - First runnable index scanning cur+1, cur+2, ... with wrap modulo NPROC. cur itself is checked last.
  - Slice expiry only, and cur is the sole runnable: stay in RUN, slice_cnt=0, no switch, cur_valid stays 1.
  - Otherwise go to SWITCH.
- State SWITCH, exactly one cycle:
  - cur_valid=0.
  - Next edge: cur_idx=selected, cur_valid=1, switch=1 for one cycle, slice_cnt=0, return to RUN.
  - Latency: trigger at edge T, cur_valid low during T+1, new cur_idx with switch high at T+2.
  - Selection is recomputed in SWITCH; if the set is now empty, go to IDLE instead.
- State IDLE:
  - cur_valid=0, idle=1.
  - On any runnable slot (after spawn or wake), go to SWITCH. Selection scans from the old cur_idx+1.
- Spawn:
  - Accepted when spawn_req=1 and spawn_ack=0. Response is registered on the next edge.
  - Success: free slot = lowest index with active=0, judged on masks before this cycle's exit. spawn_ack=1, spawn_idx=slot, active[slot]=1, blocked[slot]=0.
  - init_we=1 with init_idx=slot and init_pc=spawn_pc in the same cycle as spawn_ack.
  - No free slot: spawn_ack=1, spawn_fail=1, no init_we.
  - A slot freed by an exit in the same cycle is usable only from the next request.
- Wake:
  - Clears blocked[wake_idx]. Ignored if the slot is not active or not blocked.
  - If wake_req targets cur in the same cycle as block_req, wake wins (no lost wake). The slot stays unblocked and the switch still happens as a yield.
- Exit of the last active process: active_mask=0, go to IDLE. Only a spawn restarts execution.
- Slot 0 has no special status after reset; it may exit.

Test Plan:
- Reset, SLICE=4, spawn_pc=0x040 held → spawn_ack with spawn_idx=1, init_we with init_pc=0x040, active_mask=0x03. After the 4th inst_done: cur_valid=0 for 1 cycle, then cur_idx=1 with switch=1.
- Active slots 0,1,2, cur=2, slice expiry → wrap to cur_idx=0. Slot 0 alone, 4 inst_done → no switch, cur_idx stays 0, cur_valid never drops.
- cur=1 block_req+inst_done, slot 0 runnable → cur_idx=0, blocked_mask=0x02. wake_req idx=1 → blocked_mask=0x00. Next expiry → cur_idx=1.
- Only slot 0 active, exit_req+inst_done → active_mask=0, idle=1, cur_valid=0. spawn_pc=0x100 → slot 0 allocated, init_we, then switch to cur_idx=0, idle=0.
- All 8 slots active, spawn_req → spawn_ack=1, spawn_fail=1, no init_we. Same-cycle block_req and wake_req on cur=3 → blocked_mask bit3=0, switch to cur_idx=4.
- rst asserted in the SWITCH cycle and during a pending spawn → next edge restores reset values: cur_idx=0, cur_valid=1, active_mask=1, no spawn_ack.
